// File: rtl/seq_divider.sv
// Multi-cycle signed integer divider (radix-2 restoring on magnitudes + sign fix-up).
// Result layout matches the Booth multiplier: Z = {remainder, quotient}.
// Ports:
//   clock    - system clock, rising edge
//   clear    - asynchronous active-low reset
//   start    - division request, sampled only in IDLE
//   A, B     - signed dividend / divisor, captured on the accept edge
//   busy     - high while iterating or fixing signs
//   done     - one-cycle completion pulse; Z valid from this cycle on
//   div_zero - divisor was zero on the last accept
//   Z        - {remainder, quotient}, held until the next completion
module seq_divider #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic                 div_zero,
    output logic [2*WIDTH-1:0]   Z
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state, state_n;
    logic [WIDTH:0]       p, p_n;
    logic [WIDTH-1:0]     q, q_n;
    logic [WIDTH-1:0]     mag_b, mag_b_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic                 sign_q, sign_q_n;
    logic                 sign_r, sign_r_n;
    logic [2*WIDTH-1:0]   z_n;
    logic                 div_zero_n;
    logic                 busy_n;
    logic                 done_n;

    logic [WIDTH:0]       p_sh;
    logic [WIDTH:0]       trial;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    // Two's-complement magnitude; the most negative value maps onto itself,
    // which is the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

    // State and datapath registers
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state    <= IDLE;
            p        <= '0;
            q        <= '0;
            mag_b    <= '0;
            cnt      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            Z        <= '0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            p        <= p_n;
            q        <= q_n;
            mag_b    <= mag_b_n;
            cnt      <= cnt_n;
            sign_q   <= sign_q_n;
            sign_r   <= sign_r_n;
            Z        <= z_n;
            div_zero <= div_zero_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    // One restoring step: shift {P,Q} left, try subtracting |B| from P
    always_comb begin
        p_sh  = {p[WIDTH-1:0], q[WIDTH-1]};
        trial = p_sh - {1'b0, mag_b};
    end

    // Sign fix-up of the magnitude results
    always_comb begin
        quo_fix = sign_q ? (~q + WIDTH'(1)) : q;
        rem_fix = sign_r ? (~p[WIDTH-1:0] + WIDTH'(1)) : p[WIDTH-1:0];
    end

    // Next-state and next-register logic
    always_comb begin
        state_n    = state;
        p_n        = p;
        q_n        = q;
        mag_b_n    = mag_b;
        cnt_n      = cnt;
        sign_q_n   = sign_q;
        sign_r_n   = sign_r;
        z_n        = Z;
        div_zero_n = div_zero;

        case (state)
            IDLE: begin
                if (start) begin
                    if (B == '0) begin
                        z_n        = {A, {WIDTH{1'b1}}};
                        div_zero_n = 1'b1;
                        state_n    = DONE;
                    end else begin
                        sign_q_n   = A[WIDTH-1] ^ B[WIDTH-1];
                        sign_r_n   = A[WIDTH-1];
                        q_n        = mag(A);
                        mag_b_n    = mag(B);
                        p_n        = '0;
                        cnt_n      = '0;
                        div_zero_n = 1'b0;
                        state_n    = CALC;
                    end
                end
            end
            CALC: begin
                if (!trial[WIDTH]) begin
                    p_n = trial;
                    q_n = {q[WIDTH-2:0], 1'b1};
                end else begin
                    p_n = p_sh;
                    q_n = {q[WIDTH-2:0], 1'b0};
                end
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_n = FIX;
                end
            end
            FIX: begin
                z_n        = {rem_fix, quo_fix};
                div_zero_n = 1'b0;
                state_n    = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // done rises on the edge that leaves DONE, so it follows completion by one cycle
        busy_n = (state_n == CALC) || (state_n == FIX);
        done_n = (state == DONE);
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle signed 32-bit integer divider for the datapath ALU; it is the inverse operation of the existing combinational Booth multiplier.
- Produces a 64-bit result Z laid out like the multiplier's: Z[63:32] = remainder (HI), Z[31:0] = quotient (LO).
- Uses a radix-2 restoring algorithm on operand magnitudes, then a sign fix-up, with a start/busy/done handshake to the control unit.

Parameters:
- WIDTH, 32, operand width; Z is 2*WIDTH.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clock  input  1  single system clock, rising edge.
- clear  input  1  asynchronous, active-low reset.
- start  input  1  request a division; sampled only in IDLE.
- A  input  32  signed dividend, captured on the accept edge.
- B  input  32  signed divisor, captured on the accept edge.
- busy  output  1  high while a division is in progress (states CALC and FIX).
- done  output  1  one-cycle pulse; Z is valid from this cycle on.
- div_zero  output  1  set with done when B was 0; held until the next accept.
- Z  output  64  {remainder, quotient}; held until the next completion.

Behaviour:
- Reset (clear low, asynchronous): state=IDLE; busy=0, done=0, div_zero=0, Z=0, all internal registers cleared. A reset mid-operation aborts the division with no done pulse.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1, B!=0 (accept edge):
  - latch sign_q = A[31]^B[31] and sign_r = A[31];
  - latch |A| and |B| as 32-bit unsigned; |0x80000000| = 0x80000000;
  - clear partial remainder P (33 bits), counter=0;
  - go to CALC.
- IDLE, start=1, B=0: go to DONE; Z={A, 32'hFFFFFFFF}; div_zero=1. done is high the following cycle.
- IDLE, start=0: stay in IDLE; outputs hold.
- CALC, one iteration per edge:
  - shift {P, Q} left by one;
  - trial = P - {0,|B|}; if trial is non-negative, P=trial and Q[0]=1, else Q[0]=0;
  - counter+1; after the 32nd iteration (counter==31 on entry) go to FIX.
- FIX, one edge:
  - quotient = sign_q ? -Q : Q;
  - remainder = sign_r ? -P[31:0] : P[31:0];
  - register Z={remainder, quotient}; div_zero=0; go to DONE.
- DONE: done=1 for exactly one cycle; next edge go to IDLE. Z stays stable.
- Latency: for an accept at edge 0, the iterations occur at edges 1–32 and FIX at edge 33. done is high from edge 34 to edge 35. Divide-by-zero: done is high from edge 1 to edge 2.
- busy=1 in CALC and FIX; busy=0 in IDLE and DONE.
- start while busy or in DONE is ignored; it is not queued. A and B may change freely after the accept edge.
- Semantics: truncating division toward zero. The remainder takes the dividend's sign, or is 0. The identity A = Q*B + R holds modulo 2^32.
- Overflow case 0x80000000 / 0xFFFFFFFF: Q=0x80000000, R=0, div_zero=0; no flag is raised.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- A=100, B=7, start pulse -> done exactly 34 cycles after the accept edge; Z=0x00000002_0000000E, div_zero=0.
- A=-100 (0xFFFFFF9C), B=7 -> Z=0xFFFFFFFE_FFFFFFF2 (R=-2, Q=-14); A=100, B=-7 -> Z=0x00000002_FFFFFFF2.
- A=0x80000000, B=0xFFFFFFFF -> Z=0x00000000_80000000, div_zero=0. A=0, B=5 -> Z=0.
- A=5, B=0 -> done 1 cycle after accept, div_zero=1, Z=0x00000005_FFFFFFFF. A following valid divide clears div_zero.
- Start a division, re-pulse start with new A/B at cycle 10 -> the second request is ignored and Z reflects the first operands. Assert clear at cycle 20 -> busy=0, Z=0, no done pulse. A fresh start after release completes normally.
- Randomised signed operands (B!=0), checked against a reference model: Q truncates toward zero, R=A-Q*B, |R|<|B|, Z stable between done pulses.
